lat_mem: RTL

Fixed-latency, pipelined word memory with ready/valid request and response channels. It implements the memory endpoint behind the CPU's `imem` (fetch → decode) and `dmem` (execute → writeback) ports. Requests come from the issuing stage. Read data returns in order to the consuming stage. An internal credit counter bounds the number of outstanding reads, so a stalled consumer never loses a response.

---
 rtl/lat_mem.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/lat_mem.sv
// Fixed-latency pipelined word memory with ready/valid request and response channels
// and credit-limited in-order read responses. Optional bounds check: LAT_MEM_BOUNDS_CHECK_EN.
module lat_mem #(
   parameter int DATA_W      = 32,
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2,
   parameter int RESP_DEPTH  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_op,
   input  logic [DATA_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_data,
   output logic              err
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
   localparam int CW = $clog2(RESP_DEPTH + 1);

   logic [DATA_W-1:0] r_mem  [DEPTH_WORDS];
   logic [LATENCY-1:0] r_pv;
   logic [DATA_W-1:0] r_pd   [LATENCY];
   logic [DATA_W-1:0] r_fifo [RESP_DEPTH];
   logic [PW-1:0]     r_wp;
   logic [PW-1:0]     r_rp;
   logic [CW-1:0]     r_fcnt;
   logic [CW-1:0]     r_cnt;

   logic [AW-1:0]     w_idx;
   logic              w_accept;
   logic              w_rd_acc;
   logic              w_wr_acc;
   logic              w_oor;
   logic              w_push;
   logic              w_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(RESP_DEPTH - 1)) ? {PW{1'b0}} : p + PW'(1);
   endfunction

   // Ready depends only on the credit count and reset, never on resp_ready.
   assign req_ready  = !reset && (r_cnt < CW'(RESP_DEPTH));
   assign w_idx      = req_addr[AW+1:2];
   assign w_accept   = req_valid && req_ready;
   assign w_rd_acc   = w_accept && !req_op;
   assign w_wr_acc   = w_accept && req_op && !w_oor;
   assign w_push     = r_pv[LATENCY-1];
   assign w_pop      = resp_valid && resp_ready;
   assign resp_valid = (r_fcnt != {CW{1'b0}});
   assign resp_data  = resp_valid ? r_fifo[r_rp] : {DATA_W{1'b0}};

`ifdef LAT_MEM_BOUNDS_CHECK_EN
   logic r_err;

   assign w_oor = (req_addr >= DATA_W'(4 * DEPTH_WORDS)) || (req_addr[1:0] != 2'b00);
   assign err   = r_err;

   // Sticky error flag, cleared only by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_err <= 1'b0;
      end else if (w_accept && w_oor) begin
         r_err <= 1'b1;
      end
   end
`else
   logic w_unused_addr;

   assign w_oor         = 1'b0;
   assign err           = 1'b0;
   assign w_unused_addr = ^{req_addr[DATA_W-1:AW+2], req_addr[1:0]};
`endif

   // Memory array: writes land at the accept edge, contents are never reset.
   always_ff @(posedge clk) begin
      if (w_wr_acc) begin
         r_mem[w_idx] <= req_wdata;
      end
   end

   // Read pipeline valid bits; reset discards every in-flight read.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pv <= {LATENCY{1'b0}};
      end else begin
         r_pv[0] <= w_rd_acc;
         for (int k = 1; k < LATENCY; k++) begin
            r_pv[k] <= r_pv[k-1];
         end
      end
   end

   // Read pipeline data; out-of-range reads carry zero.
   always_ff @(posedge clk) begin
      r_pd[0] <= w_oor ? {DATA_W{1'b0}} : r_mem[w_idx];
      for (int k = 1; k < LATENCY; k++) begin
         r_pd[k] <= r_pd[k-1];
      end
   end

   // Response FIFO storage.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo[r_wp] <= r_pd[LATENCY-1];
      end
   end

   // Response FIFO pointers and occupancy.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wp   <= {PW{1'b0}};
         r_rp   <= {PW{1'b0}};
         r_fcnt <= {CW{1'b0}};
      end else begin
         if (w_push) begin
            r_wp <= ptr_inc(r_wp);
         end
         if (w_pop) begin
            r_rp <= ptr_inc(r_rp);
         end
         case ({w_push, w_pop})
            2'b10:   r_fcnt <= r_fcnt + CW'(1);
            2'b01:   r_fcnt <= r_fcnt - CW'(1);
            default: r_fcnt <= r_fcnt;
         endcase
      end
   end

   // Credit counter: reads accepted but not yet popped.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= {CW{1'b0}};
      end else begin
         case ({w_rd_acc, w_pop})
            2'b10:   r_cnt <= r_cnt + CW'(1);
            2'b01:   r_cnt <= r_cnt - CW'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

endmodule
